// File: rtl/direct_mapped_cache.sv
// direct_mapped_cache: write-back, write-allocate direct-mapped cache between a
// 32-bit Wishbone requester (ctrl_*) and a 128-bit-block Wishbone RAM (mem_*).
// Ports: clk_i/rst_i (async, active-high); ctrl_cyc/stb/we/addr/sel/dat_i in,
// ctrl_dat_o/ctrl_ack_o out; mem_cyc/stb/we/addr/sel/dat_o out, mem_dat_i/ack_i in.
module direct_mapped_cache #(
  parameter int CACHE_SIZE = 4096
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ctrl_cyc_i,
  input  logic         ctrl_stb_i,
  input  logic         ctrl_we_i,
  input  logic [14:0]  ctrl_addr_i,
  input  logic [3:0]   ctrl_sel_i,
  input  logic [31:0]  ctrl_dat_i,
  output logic [31:0]  ctrl_dat_o,
  output logic         ctrl_ack_o,
  output logic         mem_cyc_o,
  output logic         mem_stb_o,
  output logic         mem_we_o,
  output logic [14:0]  mem_addr_o,
  output logic [15:0]  mem_sel_o,
  output logic [127:0] mem_dat_o,
  input  logic [127:0] mem_dat_i,
  input  logic         mem_ack_i
);
  localparam int LINES = CACHE_SIZE / 16;
  localparam int IW = $clog2(LINES);
  localparam int TW = 15 - 4 - IW;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
  state_t state_q;
  logic [14:2] addr_q;
  logic we_q;
  logic [31:0] wdat_q;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [127:0] data_q [LINES];
  logic [TW-1:0] tag_q [LINES];
  logic ctrl_ack_q, mem_cyc_q, mem_we_q;
  logic [31:0] ctrl_dat_q;
  logic [14:0] mem_addr_q;
  logic [127:0] mem_dat_q;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0] word;
  logic [127:0] line, merged;
  logic [31:0] rword;
  logic hit, fill, line_we;
  // byte lanes and the low address bits carry no information for full-word access
  logic unused_bits;
  assign unused_bits = ^{ctrl_sel_i, ctrl_addr_i[1:0]};
  assign idx = addr_q[IW+3:4];
  assign tag = addr_q[14:IW+4];
  assign word = addr_q[3:2];
  assign line = data_q[idx];
  assign rword = line[{word, 5'd0} +: 32];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign fill = state_q == ALLOCATE && mem_cyc_q && mem_ack_i;
  assign line_we = fill || (state_q == COMPARE && hit && we_q);
  always_comb begin
    merged = line;
    merged[{word, 5'd0} +: 32] = wdat_q;
  end
  always_ff @(posedge clk_i) if (line_we) data_q[idx] <= fill ? mem_dat_i : merged;
  always_ff @(posedge clk_i) if (fill) tag_q[idx] <= tag;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdat_q     <= '0;
      ctrl_ack_q <= 1'b0;
      ctrl_dat_q <= '0;
      mem_cyc_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dat_q  <= '0;
    end else begin
      ctrl_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (ctrl_cyc_i && ctrl_stb_i) begin
          addr_q  <= ctrl_addr_i[14:2];
          we_q    <= ctrl_we_i;
          wdat_q  <= ctrl_dat_i;
          state_q <= COMPARE;
        end
        COMPARE: if (hit) begin
          ctrl_ack_q <= 1'b1;
          ctrl_dat_q <= we_q ? wdat_q : rword;
          if (we_q) dirty_q[idx] <= 1'b1;
          state_q <= IDLE;
        end else state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : ALLOCATE;
        // each memory phase enters with cyc low, so a transaction is idle for
        // at least one cycle after the previous ack before it is raised
        WRITE_BACK: if (!mem_cyc_q) begin
          mem_cyc_q  <= 1'b1;
          mem_we_q   <= 1'b1;
          mem_addr_q <= {tag_q[idx], idx, 4'b0};
          mem_dat_q  <= line;
        end else if (mem_ack_i) begin
          mem_cyc_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= ALLOCATE;
        end
        ALLOCATE: if (!mem_cyc_q) begin
          mem_cyc_q  <= 1'b1;
          mem_addr_q <= {tag, idx, 4'b0};
        end else if (mem_ack_i) begin
          mem_cyc_q     <= 1'b0;
          valid_q[idx]  <= 1'b1;
          dirty_q[idx]  <= 1'b0;
          state_q       <= COMPARE;
        end
      endcase
    end
  assign ctrl_ack_o = ctrl_ack_q;
  assign ctrl_dat_o = ctrl_dat_q;
  assign mem_cyc_o  = mem_cyc_q;
  assign mem_stb_o  = mem_cyc_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_sel_o  = '1;
  assign mem_dat_o  = mem_dat_q;
endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb_direct_mapped_cache: directed + random checks of the cache against a byte-array memory model
module tb_direct_mapped_cache;
  localparam int BUSY = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic c_cyc = 1'b0, c_stb = 1'b0, c_we = 1'b0;
  logic [14:0] c_addr = '0;
  logic [3:0] c_sel = '1;
  logic [31:0] c_wdat = '0, c_rdat;
  logic c_ack;
  logic m_cyc, m_stb, m_we, m_ack;
  logic [14:0] m_addr;
  logic [15:0] m_sel;
  logic [127:0] m_wdat, m_rdat;
  logic [127:0] ram [0:2047];
  logic [7:0] mirror [0:32767];
  int total = 0, bad = 0, rd_n = 0, wr_n = 0, busy = 0;
  logic [14:0] last_ra, last_wa;
  logic [127:0] last_wd;
  direct_mapped_cache dut (
    .clk_i(clk), .rst_i(rst),
    .ctrl_cyc_i(c_cyc), .ctrl_stb_i(c_stb), .ctrl_we_i(c_we), .ctrl_addr_i(c_addr),
    .ctrl_sel_i(c_sel), .ctrl_dat_i(c_wdat), .ctrl_dat_o(c_rdat), .ctrl_ack_o(c_ack),
    .mem_cyc_o(m_cyc), .mem_stb_o(m_stb), .mem_we_o(m_we), .mem_addr_o(m_addr),
    .mem_sel_o(m_sel), .mem_dat_o(m_wdat), .mem_dat_i(m_rdat), .mem_ack_i(m_ack)
  );
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_ack <= 1'b0;
      busy <= 0;
    end else if (m_cyc && m_stb && !m_ack) begin
      if (busy == BUSY - 1) begin
        m_ack <= 1'b1;
        busy <= 0;
        if (m_we) begin
          ram[m_addr[14:4]] <= m_wdat;
          wr_n <= wr_n + 1;
          last_wa <= m_addr;
          last_wd <= m_wdat;
        end else begin
          m_rdat <= ram[m_addr[14:4]];
          rd_n <= rd_n + 1;
          last_ra <= m_addr;
        end
      end else busy <= busy + 1;
    end else begin
      m_ack <= 1'b0;
      if (!m_cyc) busy <= 0;
    end
  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mw(input int a);
    return {mirror[a+3], mirror[a+2], mirror[a+1], mirror[a]};
  endfunction
  function automatic logic [127:0] blk(input int a);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = mirror[a+b];
    return r;
  endfunction
  task automatic wm(input int a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) mirror[a+b] = d[8*b +: 8];
  endtask
  task automatic sync_mirror();
    for (int i = 0; i < 2048; i++)
      for (int b = 0; b < 16; b++) mirror[i*16+b] = ram[i][8*b +: 8];
  endtask
  task automatic req(input logic we, input logic [14:0] a, input logic [31:0] d, input bit hold, output int n);
    c_cyc = 1'b1; c_stb = 1'b1; c_we = we; c_addr = a; c_wdat = d; n = 0;
    do begin @(negedge clk); n++; end while (!c_ack && n < 200);
    chk("ack", c_ack, 1'b1);
    if (hold) @(negedge clk);
    c_cyc = 1'b0; c_stb = 1'b0;
  endtask
  task automatic wait_dup();
    int n = 0;
    do begin @(negedge clk); n++; end while (!c_ack && n < 50);
    chk("dup_ack", c_ack, 1'b1);
  endtask
  initial begin
    int n, r0, w0;
    logic [14:0] a;
    logic [31:0] d, exp;
    logic we;
    for (int i = 0; i < 2048; i++) ram[i] <= {$urandom, $urandom, $urandom, $urandom};
    #1;
    sync_mirror();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", c_ack, 1'b0);
    chk("rst_dat", c_rdat, 32'h0);
    chk("rst_mcyc", m_cyc, 1'b0);
    chk("rst_mstb", m_stb, 1'b0);
    chk("rst_mwe", m_we, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    req(1'b0, 15'h0004, 32'h0, 1'b0, n);
    chk("cold_rd", c_rdat, mw(4));
    chk("cold_rd_cnt", rd_n, 1);
    chk("cold_rd_addr", last_ra, 15'h0000);
    chk("cold_wr_cnt", wr_n, 0);
    chk("cold_lat_gt2", n > 2, 1'b1);
    req(1'b0, 15'h0004, 32'h0, 1'b0, n);
    chk("hit_rd", c_rdat, mw(4));
    chk("hit_lat", n, 2);
    chk("hit_rd_cnt", rd_n, 1);
    wm(8, 32'hDEADBEEF);
    req(1'b1, 15'h0008, 32'hDEADBEEF, 1'b0, n);
    chk("wr_echo", c_rdat, 32'hDEADBEEF);
    chk("wr_lat", n, 2);
    req(1'b0, 15'h0008, 32'h0, 1'b0, n);
    chk("wr_readback", c_rdat, 32'hDEADBEEF);
    chk("wr_no_wb", wr_n, 0);
    req(1'b0, 15'h1008, 32'h0, 1'b0, n);
    chk("evict_rd", c_rdat, mw(15'h1008));
    chk("evict_wr_cnt", wr_n, 1);
    chk("evict_wr_addr", last_wa, 15'h0000);
    chk("evict_word2", last_wd[95:64], 32'hDEADBEEF);
    chk("evict_blk", last_wd, blk(0));
    chk("evict_rd_cnt", rd_n, 2);
    chk("evict_rd_addr", last_ra, 15'h1000);
    req(1'b0, 15'h0008, 32'h0, 1'b0, n);
    chk("thrash_rd", c_rdat, 32'hDEADBEEF);
    chk("thrash_wr_cnt", wr_n, 1);
    chk("thrash_rd_cnt", rd_n, 3);
    c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b0; c_addr = 15'h2004;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_cyc && n < 50);
    chk("fill_started", m_cyc, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midfill_ack", c_ack, 1'b0);
    chk("midfill_mcyc", m_cyc, 1'b0);
    c_cyc = 1'b0; c_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sync_mirror();
    @(negedge clk);
    r0 = rd_n;
    req(1'b0, 15'h0004, 32'h0, 1'b0, n);
    chk("post_rst_rd", c_rdat, mw(4));
    chk("post_rst_miss", rd_n, r0 + 1);
    chk("post_rst_lat_gt2", n > 2, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      a = 15'($urandom_range(0, 3) * 4);
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      if (we) wm(int'(a), d);
      exp = we ? d : mw(int'(a));
      req(we, a, d, 1'b1, n);
      chk("rnd", c_rdat, exp);
      wait_dup();
      chk("rnd_dup", c_rdat, exp);
    end
    for (int i = 0; i < 600; i++) begin
      a = 15'(($urandom_range(0, 7) << 12) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2));
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      if (we) wm(int'(a), d);
      exp = we ? d : mw(int'(a));
      req(we, a, d, 1'b0, n);
      chk("thrash_rnd", c_rdat, exp);
    end
    w0 = wr_n;
    chk("thrash_wb_seen", w0 > 1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
